// File: rtl/eg2000_joy_pkg.sv
// eg2000_joy_pkg: shared FSM states, axis map and sizes for the joystick scanner
package eg2000_joy_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE_WAIT, SAMPLE, NEXT, DONE} state_e;
  localparam int AXES = 4;
  localparam int ROWS = 6;
  localparam int AXIS_W = 6;
  localparam logic [1:0] AX_P1X = 2'd0, AX_P1Y = 2'd1, AX_P2X = 2'd2, AX_P2Y = 2'd3;
  function automatic logic [2:0] cmp_bit(input logic [1:0] a);
    return 3'd7 - {1'b0, a};
  endfunction
endpackage

// File: rtl/eg2000_joystick_scanner_if.sv
// eg2000_joystick_scanner_if: scan handshake, port A/B lines and snapshot outputs
interface eg2000_joystick_scanner_if;
  import eg2000_joy_pkg::*;
  logic start, busy, done;
  logic [AXIS_W-1:0] portA_o, p1_x_o, p1_y_o, p2_x_o, p2_y_o;
  logic [7:0] portB_i;
  logic [4*ROWS-1:0] keys_o;
  modport master (output start, portB_i,
                  input busy, done, portA_o, p1_x_o, p1_y_o, p2_x_o, p2_y_o, keys_o);
  modport slave (input start, portB_i,
                 output busy, done, portA_o, p1_x_o, p1_y_o, p2_x_o, p2_y_o, keys_o);
endinterface

// File: rtl/eg2000_joyscan_sar.sv
// eg2000_joyscan_sar: one 6-bit successive-approximation engine, MSB first
module eg2000_joyscan_sar
  import eg2000_joy_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic              keep_i,
  output logic [AXIS_W-1:0] cand_o,
  output logic [AXIS_W-1:0] res_o,
  output logic              last_o
);
  logic [AXIS_W-1:0] res_q, res_d;
  logic [2:0] bit_q, bit_d;
  assign cand_o = res_q | (AXIS_W'(1) << bit_q);
  assign res_o = res_q;
  assign last_o = bit_q == 3'd0;
  // clear rearms at the MSB; a step commits the trial bit if the comparator kept it
  always_comb begin
    res_d = clr_i ? '0 : (step_i && keep_i) ? cand_o : res_q;
    bit_d = clr_i ? 3'(AXIS_W-1) : step_i ? bit_q - 3'd1 : bit_q;
  end
  // result and bit pointer registers
  always_ff @(posedge clk) begin
    res_q <= !reset_n ? '0 : res_d;
    bit_q <= !reset_n ? 3'(AXIS_W-1) : bit_d;
  end
endmodule

// File: rtl/eg2000_joystick_scanner.sv
// eg2000_joystick_scanner: SAR axis reader and keypad row scanner; keypad phase under EG2000_JOYSCAN_KEYPAD_EN
module eg2000_joystick_scanner
  import eg2000_joy_pkg::*;
#(
  parameter int SETTLE = 2
)
(
  input logic clk,
  input logic reset_n,
  eg2000_joystick_scanner_if.slave bus
);
  state_e state_q, state_d;
  logic [3:0] cnt_q;
  logic [1:0] axis_q;
  logic [AXIS_W-1:0] porta_q, cand, res, drive_val, drive_row;
  logic [AXIS_W-1:0] work_q [AXES];
  logic [AXIS_W-1:0] snap_q [AXES];
  logic sample, kp, row_last, last, keep, axis_end, scan_end;
`ifdef EG2000_JOYSCAN_KEYPAD_EN
  localparam bit KP_EN = 1'b1;
  logic kp_q;
  logic [2:0] row_q;
  logic [4*ROWS-1:0] kwork_q, ksnap_q;
  assign kp = kp_q;
  assign row_last = row_q == 3'(ROWS-1);
  assign drive_row = ~(AXIS_W'(1) << row_q);
  assign bus.keys_o = ksnap_q;
  // keypad phase follows the last axis; rows land in a working copy until DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kp_q <= 1'b0;
      row_q <= '0;
      kwork_q <= '0;
      ksnap_q <= '0;
    end else begin
      kp_q <= state_q == IDLE ? 1'b0 : (axis_end && axis_q == AX_P2Y) ? 1'b1 : kp_q;
      row_q <= state_q == IDLE ? '0 : (sample && kp_q) ? row_q + 3'd1 : row_q;
      if (sample && kp_q) kwork_q[{row_q, 2'b00} +: 4] <= ~bus.portB_i[3:0];
      if (state_q == DONE) ksnap_q <= kwork_q;
    end
  end
`else
  localparam bit KP_EN = 1'b0;
  logic unused_rows;
  assign kp = 1'b0;
  assign row_last = 1'b0;
  assign drive_row = '1;
  assign bus.keys_o = '0;
  assign unused_rows = ^bus.portB_i[3:0];
`endif
  assign sample = state_q == SAMPLE;
  assign keep = bus.portB_i[cmp_bit(axis_q)];
  assign axis_end = sample && !kp && last;
  assign scan_end = kp ? row_last : (last && axis_q == AX_P2Y && !KP_EN);
  assign drive_val = kp ? drive_row : cand - AXIS_W'(1);
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.portA_o = porta_q;
  assign bus.p1_x_o = snap_q[AX_P1X];
  assign bus.p1_y_o = snap_q[AX_P1Y];
  assign bus.p2_x_o = snap_q[AX_P2X];
  assign bus.p2_y_o = snap_q[AX_P2Y];
  eg2000_joyscan_sar u_sar (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (state_q == IDLE || axis_end),
    .step_i (sample && !kp && !last),
    .keep_i (keep),
    .cand_o (cand),
    .res_o  (res),
    .last_o (last)
  );
  // state register
  always_ff @(posedge clk) state_q <= !reset_n ? IDLE : state_d;
  // each step is DRIVE, SETTLE-1 wait cycles, then SAMPLE which picks the next step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = bus.start ? DRIVE : IDLE;
      DRIVE:       state_d = SETTLE == 1 ? SAMPLE : SETTLE_WAIT;
      SETTLE_WAIT: state_d = cnt_q == 4'(SETTLE-2) ? SAMPLE : SETTLE_WAIT;
      SAMPLE:      state_d = scan_end ? DONE : DRIVE;
      default:     state_d = IDLE;
    endcase
  end
  // select lines, settle counter, axis index, per-axis latches and snapshot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      axis_q <= '0;
      porta_q <= '1;
      work_q <= '{default: '0};
      snap_q <= '{default: '0};
    end else begin
      cnt_q <= state_q == SETTLE_WAIT ? cnt_q + 4'd1 : '0;
      porta_q <= state_q == DRIVE ? drive_val : state_q == DONE ? '1 : porta_q;
      axis_q <= state_q == IDLE ? '0 : axis_end ? axis_q + 2'd1 : axis_q;
      if (axis_end) work_q[axis_q] <= keep ? cand : res;
      if (state_q == DONE) snap_q <= work_q;
    end
  end
endmodule

// File: tb/tb_eg2000_joystick_scanner.sv
// tb_eg2000_joystick_scanner: randomized scans against a responder and expected-snapshot model
module tb_eg2000_joystick_scanner;
  localparam int SETTLE = 2;
`ifdef EG2000_JOYSCAN_KEYPAD_EN
  localparam int STEPS = 30;
  localparam bit KP = 1'b1;
`else
  localparam int STEPS = 24;
  localparam bit KP = 1'b0;
`endif
  localparam int LAT = STEPS * (SETTLE + 1) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int axis_val [4];
  logic [23:0] key_lo;
  logic [23:0] exp_axes, exp_keys, prev_axes, prev_keys;
  logic [7:0] pb;

  eg2000_joystick_scanner_if bus();
  eg2000_joystick_scanner #(.SETTLE(SETTLE)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // responder: comparator high while the (saturated) axis value exceeds port A;
  // low nibble returns the active-low data of the single row pulled low
  always_comb begin
    pb = {4'h0, 4'hF};
    for (int a = 0; a < 4; a++)
      pb[7-a] = ((axis_val[a] > 63) ? 63 : axis_val[a]) > int'(bus.portA_o);
    for (int r = 0; r < 6; r++)
      if (bus.portA_o == ~(6'd1 << r)) pb[3:0] = key_lo[4*r +: 4];
    bus.portB_i = pb;
  end

  function automatic logic [5:0] sat(input int v);
    return v > 63 ? 6'h3F : 6'(v);
  endfunction

  function automatic logic [23:0] got_axes();
    return {bus.p1_x_o, bus.p1_y_o, bus.p2_x_o, bus.p2_y_o};
  endfunction

  task automatic load(input int a0, input int a1, input int a2, input int a3, input logic [23:0] kl);
    prev_axes = exp_axes;
    prev_keys = exp_keys;
    axis_val = '{a0, a1, a2, a3};
    key_lo = kl;
    exp_axes = {sat(a0), sat(a1), sat(a2), sat(a3)};
    exp_keys = KP ? ~kl : 24'h0;
  endtask

  // one scan from an IDLE cycle; observations only, callers compare
  task automatic scan(input int pulse_at, output int dc, output int nd, output int nb, output int hb);
    dc = -1; nd = 0; nb = 0; hb = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= LAT + 4; n++) begin
      if (bus.busy) nb++;
      if (bus.done) begin
        nd++;
        if (dc < 0) dc = n;
      end else if (dc < 0 && (got_axes() !== prev_axes || bus.keys_o !== prev_keys)) hb++;
      bus.start = (n == pulse_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.portA_o !== 6'h3F) begin errors++; $display("FAIL reset_porta: got %h expected 3f", bus.portA_o); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (got_axes() !== 24'h0) begin errors++; $display("FAIL reset_axes: got %h expected 0", got_axes()); end
    checks++; if (bus.keys_o !== 24'h0) begin errors++; $display("FAIL reset_keys: got %h expected 0", bus.keys_o); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_axes();
    int dc, nd, nb, hb;
    load(42, 0, 63, 31, 24'hFFFBFF);
    scan(0, dc, nd, nb, hb);
    checks++; if (dc !== LAT) begin errors++; $display("FAIL axes_done_cycle: got %0d expected %0d", dc, LAT); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL axes_done_count: got %0d expected 1", nd); end
    checks++; if (nb !== LAT) begin errors++; $display("FAIL axes_busy_cycles: got %0d expected %0d", nb, LAT); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL axes_partial_visible: got %0d expected 0", hb); end
    checks++; if (got_axes() !== exp_axes) begin errors++; $display("FAIL axes_values: got %h expected %h", got_axes(), exp_axes); end
    checks++; if (bus.keys_o !== exp_keys) begin errors++; $display("FAIL axes_keys: got %h expected %h", bus.keys_o, exp_keys); end
    checks++; if (bus.portA_o !== 6'h3F) begin errors++; $display("FAIL axes_idle_porta: got %h expected 3f", bus.portA_o); end
  endtask

  task automatic test_saturation();
    int dc, nd, nb, hb;
    load(95, 1, 64, 0, 24'hFFFFFF);
    scan(0, dc, nd, nb, hb);
    checks++; if (got_axes() !== {6'h3F, 6'h01, 6'h3F, 6'h00}) begin errors++; $display("FAIL sat_values: got %h expected %h", got_axes(), {6'h3F, 6'h01, 6'h3F, 6'h00}); end
    checks++; if (bus.keys_o !== 24'h0) begin errors++; $display("FAIL sat_keys: got %h expected 0", bus.keys_o); end
  endtask

  task automatic test_random();
    int dc, nd, nb, hb;
    for (int i = 0; i < 6; i++) begin
      load($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(0, 100), 24'($urandom));
      scan(0, dc, nd, nb, hb);
      checks++; if (dc !== LAT || nd !== 1) begin errors++; $display("FAIL rand_done[%0d]: got cycle %0d count %0d expected cycle %0d count 1", i, dc, nd, LAT); end
      checks++; if (hb !== 0) begin errors++; $display("FAIL rand_partial_visible[%0d]: got %0d expected 0", i, hb); end
      checks++; if (got_axes() !== exp_axes) begin errors++; $display("FAIL rand_axes[%0d]: got %h expected %h", i, got_axes(), exp_axes); end
      checks++; if (bus.keys_o !== exp_keys) begin errors++; $display("FAIL rand_keys[%0d]: got %h expected %h", i, bus.keys_o, exp_keys); end
    end
  endtask

  task automatic test_start_ignored();
    int dc, nd, nb, hb;
    load($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), 24'($urandom));
    scan(10, dc, nd, nb, hb);
    checks++; if (nd !== 1 || dc !== LAT) begin errors++; $display("FAIL busy_start: got count %0d cycle %0d expected count 1 cycle %0d", nd, dc, LAT); end
    checks++; if (got_axes() !== exp_axes) begin errors++; $display("FAIL busy_start_axes: got %h expected %h", got_axes(), exp_axes); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, extra, idle_busy, drive_busy;
    load($urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 80), 24'($urandom));
    d1 = -1; d2 = -1; extra = 0; idle_busy = -1; drive_busy = -1;
    bus.start = 1'b1;
    for (int n = 1; n <= 2 * LAT + 8; n++) begin
      @(posedge clk); #1;
      if (d1 > 0 && n == d1 + 1) idle_busy = int'(bus.busy);
      if (d1 > 0 && n == d1 + 2) begin
        drive_busy = int'(bus.busy);
        bus.start = 1'b0;
      end
      if (bus.done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
        else extra++;
      end
    end
    bus.start = 1'b0;
    checks++; if (d1 !== LAT) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", d1, LAT); end
    checks++; if (idle_busy !== 0 || drive_busy !== 1) begin errors++; $display("FAIL b2b_gap: got busy %0d,%0d expected 0,1", idle_busy, drive_busy); end
    checks++; if (d2 !== 2 * LAT + 1 || extra !== 0) begin errors++; $display("FAIL b2b_second_done: got %0d extra %0d expected %0d extra 0", d2, extra, 2 * LAT + 1); end
    checks++; if (got_axes() !== exp_axes || bus.keys_o !== exp_keys) begin errors++; $display("FAIL b2b_values: got %h/%h expected %h/%h", got_axes(), bus.keys_o, exp_axes, exp_keys); end
  endtask

  task automatic test_reset_mid();
    int nd, nb;
    load($urandom_range(1, 63), $urandom_range(1, 63), $urandom_range(1, 63), $urandom_range(1, 63), 24'($urandom));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_state: got busy %b done %b expected 0 0", bus.busy, bus.done); end
    checks++; if (bus.portA_o !== 6'h3F) begin errors++; $display("FAIL midreset_porta: got %h expected 3f", bus.portA_o); end
    checks++; if (got_axes() !== 24'h0 || bus.keys_o !== 24'h0) begin errors++; $display("FAIL midreset_outputs: got %h/%h expected 0/0", got_axes(), bus.keys_o); end
    nd = 0; nb = 0;
    for (int n = 0; n < LAT + 5; n++) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
      if (bus.busy) nb++;
    end
    checks++; if (nd !== 0 || nb !== 0) begin errors++; $display("FAIL midreset_no_done: got done %0d busy %0d expected 0 0", nd, nb); end
    exp_axes = 24'h0;
    exp_keys = 24'h0;
  endtask

  initial begin
    bus.start = 1'b0;
    exp_axes = 24'h0;
    exp_keys = 24'h0;
    load(0, 0, 0, 0, 24'hFFFFFF);
    test_reset();
    test_axes();
    test_saturation();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
